// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD instruction engine:
// phase encoding, 50 MHz default timing and command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP,
        WAIT
    } lcd_state_e;

    localparam int T_SETUP_50M      = 2;
    localparam int T_PULSE_50M      = 12;
    localparam int T_HOLD_50M       = 1;
    localparam int T_NIBBLE_GAP_50M = 50;
    localparam int T_CMD_WAIT_50M   = 2000;
    localparam int T_LONG_WAIT_50M  = 82000;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int RS = 9;
    localparam int RW = 8;

    // Clear and return-home (0x01..0x03 with RS=0) need the long settle time
    function automatic logic is_long_cmd(input logic [9:0] d);
        return !d[RS] &&
               (d[7:0] == CMD_CLEAR ||
                d[7:0] == CMD_HOME  ||
                d[7:0] == (CMD_CLEAR | CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_instr_engine_if.sv
// Instruction handshake between a sequencer (master)
// and the LCD instruction engine (slave).
interface lcd_instr_engine_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] db;

    modport master (
        output instr_valid,
        output db,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  db,
        output instr_ready
    );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing each engine phase;
// saturates at zero so an idle engine sees zero forever.
module lcd_phase_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on request, else count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lcd_instr_engine.sv
// Serialises one {RS,RW,D} instruction onto an HD44780-style
// bus in 4- or 8-bit mode, with all pin timing self-generated.
module lcd_instr_engine
    import lcd_pkg::*;
#(
    parameter int BUS_W        = 4,
    parameter int T_SETUP      = T_SETUP_50M,
    parameter int T_PULSE      = T_PULSE_50M,
    parameter int T_HOLD       = T_HOLD_50M,
    parameter int T_NIBBLE_GAP = T_NIBBLE_GAP_50M,
    parameter int T_CMD_WAIT   = T_CMD_WAIT_50M,
    parameter int T_LONG_WAIT  = T_LONG_WAIT_50M,
    parameter int CNT_W        = 17
) (
    input  logic               clk,
    input  logic               reset,
    lcd_instr_engine_if.slave  bus,
    output logic               LCD_RS,
    output logic               LCD_RW,
    output logic               LCD_E,
    output logic [BUS_W-1:0]   SF_D,
    output logic               done
);

    lcd_state_e state_q, state_d;

    logic [3:0]       lo_q, lo_d;
    logic             long_q, long_d;
    logic             nib_lo_q, nib_lo_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic             e_q, e_d;
    logic [BUS_W-1:0] sf_q, sf_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_unused_value;
    logic             tmr_zero;

    logic [BUS_W-1:0] first_w;
    logic [BUS_W-1:0] second_w;

    lcd_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_unused_value),
        .zero     (tmr_zero)
    );

    // First transfer is the whole byte or its upper nibble
    if (BUS_W == 8) begin : g_byte
        assign first_w = BUS_W'(bus.db[7:0]);
    end else begin : g_nibble
        assign first_w = BUS_W'(bus.db[7:4]);
    end

    assign second_w = BUS_W'(lo_q);

    // Phase sequencing; pin values are computed from the next phase
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        long_d   = long_q;
        nib_lo_d = nib_lo_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        sf_d     = sf_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    lo_d     = bus.db[3:0];
                    long_d   = is_long_cmd(bus.db);
                    nib_lo_d = 1'b0;
                    rs_d     = bus.db[RS];
                    rw_d     = bus.db[RW];
                    sf_d     = first_w;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_PULSE - 1);
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (BUS_W == 4 && !nib_lo_q) begin
                        tmr_val = CNT_W'(T_NIBBLE_GAP - 1);
                        state_d = GAP;
                    end else begin
                        tmr_val = long_q ? CNT_W'(T_LONG_WAIT - 1)
                                         : CNT_W'(T_CMD_WAIT - 1);
                        state_d = WAIT;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    nib_lo_d = 1'b1;
                    sf_d     = second_w;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                    state_d  = SETUP;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        e_d     = (state_d == PULSE);
        done_d  = (state_q == WAIT) && tmr_zero;
        ready_d = (state_d == IDLE);
    end

    // State and registered pin outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            long_q   <= 1'b0;
            nib_lo_q <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            e_q      <= 1'b0;
            sf_q     <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            long_q   <= long_d;
            nib_lo_q <= nib_lo_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            e_q      <= e_d;
            sf_q     <= sf_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign LCD_RS          = rs_q;
    assign LCD_RW          = rw_q;
    assign LCD_E           = e_q;
    assign SF_D            = sf_q;
    assign done            = done_q;

endmodule
